// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit feeding the HI/LO pair.
// Radix-2 Booth multiply and restoring divide, one step per cycle over WIDTH cycles.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned BOOTH_W = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [BOOTH_W-1:0] booth_q, booth_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               quot_neg_q, quot_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH:0]     acc_ext_c, mc_ext_c, booth_sum_c;
    logic [BOOTH_W-1:0] booth_next_c;
    logic [WIDTH:0]     a_mag_c, b_mag_c;
    logic [WIDTH:0]     div_shift_c, div_rem_next_c;
    logic               div_fits_c;
    logic [WIDTH-1:0]   div_quot_next_c, quot_final_c, rem_final_c;

    // Booth step: the add is done in WIDTH+1 bits so the shifted-in sign is exact
    always_comb begin
        acc_ext_c = {booth_q[BOOTH_W-1], booth_q[BOOTH_W-1 -: WIDTH]};
        mc_ext_c  = {mcand_q[WIDTH-1], mcand_q};
        case (booth_q[1:0])
            2'b01:   booth_sum_c = acc_ext_c + mc_ext_c;
            2'b10:   booth_sum_c = acc_ext_c - mc_ext_c;
            default: booth_sum_c = acc_ext_c;
        endcase
        booth_next_c = {booth_sum_c, booth_q[WIDTH:1]};
    end

    // Operand magnitudes in WIDTH+1 bits so the most negative value survives
    always_comb begin
        a_mag_c = a[WIDTH-1] ? (WIDTH+1)'(-{a[WIDTH-1], a}) : {1'b0, a};
        b_mag_c = b[WIDTH-1] ? (WIDTH+1)'(-{b[WIDTH-1], b}) : {1'b0, b};
    end

    // Restoring divide step and final sign correction
    always_comb begin
        div_shift_c     = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
        div_fits_c      = (div_shift_c >= {1'b0, dvsr_q});
        div_rem_next_c  = div_fits_c ? (div_shift_c - {1'b0, dvsr_q}) : div_shift_c;
        div_quot_next_c = {quot_q[WIDTH-2:0], div_fits_c};
        quot_final_c    = quot_neg_q ? WIDTH'(-div_quot_next_c) : div_quot_next_c;
        rem_final_c     = rem_neg_q ? WIDTH'(-div_rem_next_c[WIDTH-1:0])
                                    : div_rem_next_c[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        booth_d    = booth_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        zero_d     = zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start_mult) begin
                    mcand_d = a;
                    booth_d = {{WIDTH{1'b0}}, b, 1'b0};
                    cnt_d   = '0;
                    state_d = S_MULT;
                end else if (start_div) begin
                    if (b != '0) begin
                        dvsr_d     = b_mag_c[WIDTH-1:0];
                        quot_d     = a_mag_c[WIDTH-1:0];
                        rem_d      = '0;
                        quot_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                        rem_neg_d  = a[WIDTH-1];
                        cnt_d      = '0;
                        state_d    = S_DIV;
                    end else begin
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_MULT: begin
                booth_d = booth_next_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    hi_d    = booth_next_c[BOOTH_W-1:WIDTH+1];
                    lo_d    = booth_next_c[WIDTH:1];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                rem_d  = div_rem_next_c;
                quot_d = div_quot_next_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    hi_d    = rem_final_c;
                    lo_d    = quot_final_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                zero_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        div_zero_d = (state_d == S_DONE) && zero_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            booth_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            booth_q    <= booth_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            zero_q     <= zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: fixed vectors, corner sequences,
// and random operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        sm;
        logic        sd;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one start and wait (bounded) for done; returns latency in cycles after the start cycle
    task automatic run_op(input logic sm, input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] got_hi, output logic [31:0] got_lo,
                          output logic got_dz, output int lat);
        start_mult = sm;
        start_div  = sd;
        a          = av;
        b          = bv;
        step();
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = $urandom;
        b          = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        got_hi = hi;
        got_lo = lo;
        got_dz = div_zero;
        step();
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    logic [31:0] ref_hi, ref_lo;

    task automatic model(input logic is_div, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] e_hi, output logic [31:0] e_lo,
                         output logic e_dz, output int e_lat);
        longint p, q, r;
        e_dz  = 1'b0;
        e_lat = 33;
        if (!is_div) begin
            p = longint'($signed(av)) * longint'($signed(bv));
            ref_hi = p[63:32];
            ref_lo = p[31:0];
        end else if (bv == 32'd0) begin
            e_dz  = 1'b1;
            e_lat = 1;
        end else begin
            q = longint'($signed(av)) / longint'($signed(bv));
            r = longint'($signed(av)) % longint'($signed(bv));
            ref_hi = r[31:0];
            ref_lo = q[31:0];
        end
        e_hi = ref_hi;
        e_lo = ref_lo;
    endtask

    vec_t        vecs[$];
    logic [31:0] g_hi, g_lo, e_hi, e_lo;
    logic        g_dz, e_dz;
    int          lat, e_lat;

    initial begin
        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = '0;
        b          = '0;

        vecs.push_back('{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33});
        // divide by zero keeps the product loaded by the previous entry
        vecs.push_back('{1'b0, 1'b1, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1});
        // both starts high: multiply wins (6*3, not 6/3)
        vecs.push_back('{1'b1, 1'b1, 32'd6,        32'd3,        32'd0,        32'd18,       1'b0, 33});

        step();
        step();
        reset = 1'b0;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div_zero", 64'(div_zero), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].sm, vecs[i].sd, vecs[i].av, vecs[i].bv, g_hi, g_lo, g_dz, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_hi", i), 64'(g_hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(g_lo), 64'(vecs[i].exp_lo));
            chk($sformatf("vec%0d_div_zero", i), 64'(g_dz), 64'(vecs[i].exp_dz));
        end

        // Start pulse during a divide must be ignored
        begin
            int n_done, d_cyc, busy_low;
            logic [31:0] cap_hi, cap_lo;
            n_done = 0; d_cyc = 0; busy_low = 0; cap_hi = '0; cap_lo = '0;
            start_div = 1'b1; a = 32'd1000; b = 32'd3;
            step();
            start_div = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                if (done) begin
                    n_done++;
                    d_cyc  = c;
                    cap_hi = hi;
                    cap_lo = lo;
                end
                if (c <= 33 && !busy) busy_low++;
                if (c == 5) begin
                    start_mult = 1'b1;
                    a = 32'd11;
                    b = 32'd13;
                end
                step();
                start_mult = 1'b0;
            end
            chk("ignore_start_done_count", 64'(n_done), 64'd1);
            chk("ignore_start_done_cycle", 64'(d_cyc), 64'd33);
            chk("ignore_start_busy_held", 64'(busy_low), 64'd0);
            chk("ignore_start_lo", 64'(cap_lo), 64'd333);
            chk("ignore_start_hi", 64'(cap_hi), 64'd1);
            chk("ignore_start_idle", 64'(busy), 64'd0);
        end

        // Reset in the middle of a multiply
        begin
            int n_done;
            n_done = 0;
            start_mult = 1'b1; a = 32'd12345; b = 32'd678;
            step();
            start_mult = 1'b0;
            for (int c = 1; c < 10; c++) step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("midreset_busy", 64'(busy), 64'd0);
            chk("midreset_hi", 64'(hi), 64'd0);
            chk("midreset_lo", 64'(lo), 64'd0);
            for (int c = 0; c < 40; c++) begin
                if (done) n_done++;
                step();
            end
            chk("midreset_no_done", 64'(n_done), 64'd0);
        end

        // Random operations against the reference model (state is at reset values here)
        ref_hi = '0;
        ref_lo = '0;
        for (int i = 0; i < 150; i++) begin
            logic        op;
            logic [31:0] av, bv;
            int          sel;
            op  = 1'($urandom_range(0, 1));
            av  = $urandom;
            bv  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) bv = 32'd0;
            if (sel == 1) av = 32'h80000000;
            if (sel == 2) bv = 32'hFFFFFFFF;
            if (sel == 3) bv = 32'($urandom_range(1, 15));
            if (sel == 4) bv = 32'h80000000;
            model(op, av, bv, e_hi, e_lo, e_dz, e_lat);
            run_op(!op, op, av, bv, g_hi, g_lo, g_dz, lat);
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(e_lat));
            chk($sformatf("rand%0d_hi", i), 64'(g_hi), 64'(e_hi));
            chk($sformatf("rand%0d_lo", i), 64'(g_lo), 64'(e_lo));
            chk($sformatf("rand%0d_div_zero", i), 64'(g_dz), 64'(e_dz));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
